// File: rtl/down_pkg.sv
// rtl/down_pkg.sv - rate/state encodings and frame length shared by the down176 path
package down_pkg;

    typedef enum logic [1:0] {
        PCM441 = 2'b00,
        PCM882 = 2'b01,
        PCM176 = 2'b10,
        PCM352 = 2'b11
    } rate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int CNT_W = 10;
    localparam int FL_W  = 11;

    function automatic logic [FL_W-1:0] frame_len(input rate_t rate);
        case (rate)
            PCM352:  frame_len = 11'd128;
            PCM176:  frame_len = 11'd256;
            PCM882:  frame_len = 11'd512;
            default: frame_len = 11'd1024;
        endcase
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - synchronous FIFO of stereo pairs with occupancy count
module pair_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_d;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CW'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/down_frame_sched.sv
// rtl/down_frame_sched.sv - bit/word clock generator and per-frame pair scheduler for down176
module down_frame_sched
    import down_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 en,
    input  logic [1:0]           ctrl,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_l,
    input  logic signed [DW-1:0] in_r,
    output logic                 obick,
    output logic                 olrck,
    output logic signed [DW-1:0] oldata,
    output logic signed [DW-1:0] ordata,
    output logic                 busy,
    output logic                 underrun,
    output logic                 rate_chg
);
    localparam int FCW = $clog2(DEPTH) + 1;

    state_t              state_q, state_d;
    rate_t               rate_q, rate_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FL_W-1:0]     fl;
    logic [CNT_W-1:0]    fl_m1;
    logic [CNT_W-1:0]    hl_m1;
    logic                bick_d, lrck_d, underrun_d, rate_chg_d;
    logic signed [DW-1:0] ldata_d, rdata_d;
    logic                pop_req;
    logic                rst_done;
    logic                fifo_push;
    logic [2*DW-1:0]     head;
    logic [FCW-1:0]      fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    assign in_ready  = rst_done && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    pair_fifo #(.W(2*DW), .DEPTH(DEPTH)) u_fifo (
        .pclk  (pclk),
        .preset(preset),
        .push  (fifo_push),
        .pop   (pop_req),
        .wdata ({in_l, in_r}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fl    = frame_len(rate_q);
    assign fl_m1 = CNT_W'(fl - FL_W'(1));
    assign hl_m1 = CNT_W'((fl >> 1) - FL_W'(1));

    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        cnt_d      = cnt_q;
        bick_d     = obick;
        lrck_d     = olrck;
        ldata_d    = oldata;
        rdata_d    = ordata;
        underrun_d = 1'b0;
        rate_chg_d = 1'b0;
        pop_req    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                bick_d  = 1'b0;
                lrck_d  = 1'b0;
                ldata_d = '0;
                rdata_d = '0;
                rate_d  = rate_t'(ctrl);
                if (en) state_d = PRIME;
            end
            PRIME: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (fifo_count >= FCW'(2)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    bick_d  = 1'b0;
                    lrck_d  = 1'b0;
                    pop_req = 1'b1;
                end
            end
            RUN: begin
                bick_d = !obick;
                if (cnt_q == fl_m1) begin
                    cnt_d  = '0;
                    lrck_d = 1'b0;
                    // a stop request only takes effect once the frame has completed
                    if (!en) begin
                        state_d = IDLE;
                        bick_d  = 1'b0;
                        ldata_d = '0;
                        rdata_d = '0;
                    end else begin
                        pop_req = 1'b1;
                        if (rate_t'(ctrl) != rate_q) begin
                            rate_d     = rate_t'(ctrl);
                            rate_chg_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == hl_m1) lrck_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop_req) begin
            if (fifo_empty) begin
                ldata_d    = '0;
                rdata_d    = '0;
                underrun_d = 1'b1;
            end else begin
                ldata_d = head[2*DW-1:DW];
                rdata_d = head[DW-1:0];
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= IDLE;
            rate_q   <= PCM441;
            cnt_q    <= '0;
            obick    <= 1'b0;
            olrck    <= 1'b0;
            oldata   <= '0;
            ordata   <= '0;
            underrun <= 1'b0;
            rate_chg <= 1'b0;
            busy     <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            cnt_q    <= cnt_d;
            obick    <= bick_d;
            olrck    <= lrck_d;
            oldata   <= ldata_d;
            ordata   <= rdata_d;
            underrun <= underrun_d;
            rate_chg <= rate_chg_d;
            busy     <= (state_d != IDLE);
            rst_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_down_frame_sched.sv
// tb/tb_down_frame_sched.sv - scoreboard bench for down_frame_sched
module tb_down_frame_sched;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic                 pclk = 1'b0;
    logic                 preset;
    logic                 en;
    logic [1:0]           ctrl;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_l, in_r;
    logic                 obick, olrck;
    logic signed [DW-1:0] oldata, ordata;
    logic                 busy, underrun, rate_chg;

    down_frame_sched #(.DW(DW), .DEPTH(DEPTH)) dut (
        .pclk(pclk), .preset(preset), .en(en), .ctrl(ctrl),
        .in_valid(in_valid), .in_ready(in_ready), .in_l(in_l), .in_r(in_r),
        .obick(obick), .olrck(olrck), .oldata(oldata), .ordata(ordata),
        .busy(busy), .underrun(underrun), .rate_chg(rate_chg)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;
    int bcount = 0;
    int un_count = 0;

    logic mon_en = 1'b0;
    logic feed_on = 1'b0;
    int   fixed_req = 0;
    int   fixed_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fl_of(input logic [1:0] r);
        return 1024 >> r;
    endfunction

    // source: a fixed number of (1000,-1000) pairs, then random pairs while feed_on
    initial begin
        logic acc, cur_fixed;
        in_valid = 1'b0; in_l = '0; in_r = '0; cur_fixed = 1'b0;
        forever begin
            @(negedge pclk);
            acc = in_valid && in_ready && !preset;
            @(posedge pclk);
            #1;
            if (acc && cur_fixed) fixed_done++;
            if (fixed_done < fixed_req) begin
                in_valid = 1'b1; in_l = 1000; in_r = -1000; cur_fixed = 1'b1;
            end else if (feed_on) begin
                in_valid = 1'b1; in_l = $urandom; in_r = $urandom; cur_fixed = 1'b0;
            end else begin
                in_valid = 1'b0; cur_fixed = 1'b0;
            end
        end
    end

    // monitor: reference model of frames, pops and FIFO occupancy
    logic [2*DW-1:0]      exp_q[$];
    logic                 in_run = 1'b0;
    int                   cyc = 0;
    logic [1:0]           mrate = 2'b00;
    logic signed [DW-1:0] cur_l = '0, cur_r = '0;
    logic                 pend = 1'b0;
    logic [2*DW-1:0]      pend_data = '0;
    logic                 prev_bick = 1'b0, prev_lrck = 1'b0, prev_en = 1'b0;
    logic [1:0]           prev_ctrl = 2'b00;

    always @(negedge pclk) begin
        logic was_run, bnd, exp_un;
        logic [2*DW-1:0] e;
        if (!mon_en) begin
            exp_q.delete(); in_run = 1'b0; pend = 1'b0; cyc = 0;
        end else begin
            was_run = in_run;
            if (in_run) cyc++;
            bnd = in_run && prev_lrck && !olrck;
            if (was_run) check("obick_toggle", obick, !prev_bick);
            if (bnd) begin
                bcount++;
                check("frame_len", cyc, fl_of(mrate));
                check("busy_at_boundary", busy, prev_en);
                if (prev_en) begin
                    check("rate_chg_boundary", rate_chg, prev_ctrl != mrate);
                    mrate = prev_ctrl;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        cur_l = e[2*DW-1:DW]; cur_r = e[DW-1:0]; exp_un = 1'b0;
                    end else begin
                        cur_l = '0; cur_r = '0; exp_un = 1'b1;
                    end
                    check("underrun_boundary", underrun, exp_un);
                    if (underrun) un_count++;
                end else begin
                    check("rate_chg_exit", rate_chg, 1'b0);
                    check("underrun_exit", underrun, 1'b0);
                    in_run = 1'b0;
                end
                cyc = 0;
            end else begin
                check("rate_chg_quiet", rate_chg, 1'b0);
                check("underrun_quiet", underrun, 1'b0);
            end
            if (!in_run && busy && obick) begin
                in_run = 1'b1; cyc = 1; mrate = prev_ctrl;
                check("run_start_fifo_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    cur_l = e[2*DW-1:DW]; cur_r = e[DW-1:0];
                end
            end
            if (in_run) begin
                check("busy_run", busy, 1'b1);
                check("oldata", oldata, cur_l);
                check("ordata", ordata, cur_r);
                check("olrck_level", olrck, cyc >= fl_of(mrate) / 2);
            end else if (!busy) begin
                check("idle_obick", obick, 1'b0);
                check("idle_olrck", olrck, 1'b0);
                check("idle_oldata", oldata, '0);
                check("idle_ordata", ordata, '0);
            end else begin
                check("prime_obick", obick, 1'b0);
                check("prime_olrck", olrck, 1'b0);
            end
            if (pend) exp_q.push_back(pend_data);
            if (!busy || in_run) check("in_ready", in_ready, exp_q.size() < DEPTH);
            pend = in_valid && in_ready;
            pend_data = {in_l, in_r};
        end
        prev_bick = obick; prev_lrck = olrck; prev_en = en; prev_ctrl = ctrl;
    end

    task automatic wait_bnd(input int n);
        int target, budget;
        target = bcount + n;
        budget = n * 1100 + 50;
        while (bcount < target && budget > 0) begin
            @(posedge pclk);
            budget--;
        end
        check("boundary_timeout", bcount >= target, 1'b1);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        int u0, pushes, budget;
        preset = 1'b1; en = 1'b0; ctrl = 2'b10;
        @(negedge pclk);
        check("rst_obick", obick, 1'b0);
        check("rst_olrck", olrck, 1'b0);
        check("rst_oldata", oldata, '0);
        check("rst_ordata", ordata, '0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_rate_chg", rate_chg, 1'b0);
        tick(2);
        preset = 1'b0;
        tick(1);
        check("in_ready_after_reset", in_ready, 1'b1);
        mon_en = 1'b1;

        // three fixed pairs, five frames at 256: frames 4 and 5 underrun
        fixed_req = 3;
        budget = 50;
        while (fixed_done < 3 && budget > 0) begin @(posedge pclk); budget--; end
        check("prefill_timeout", fixed_done, 3);
        tick(1);
        en = 1'b1;
        u0 = un_count;
        wait_bnd(4);
        check("underrun_pulses", un_count - u0, 2);

        // rate changes with a continuous source
        feed_on = 1'b1;
        wait_bnd(1);
        tick(49);
        ctrl = 2'b11;
        wait_bnd(1);
        wait_bnd(2);
        ctrl = 2'b00;
        wait_bnd(3);
        ctrl = 2'b10;
        wait_bnd(2);

        // stop request mid-frame
        wait_bnd(1);
        tick(9);
        en = 1'b0;
        for (int i = 0; i < 400 && busy; i++) @(posedge pclk);
        #1;
        check("busy_fall", busy, 1'b0);

        // fill while idle, then restart from the retained contents
        tick(12);
        en = 1'b1;
        wait_bnd(2);
        tick(30);

        // asynchronous reset mid-frame
        feed_on = 1'b0;
        tick(1);
        mon_en = 1'b0;
        #2 preset = 1'b1;
        #1;
        check("amid_obick", obick, 1'b0);
        check("amid_olrck", olrck, 1'b0);
        check("amid_oldata", oldata, '0);
        check("amid_ordata", ordata, '0);
        check("amid_busy", busy, 1'b0);
        check("amid_in_ready", in_ready, 1'b0);
        check("amid_underrun", underrun, 1'b0);
        check("amid_rate_chg", rate_chg, 1'b0);
        en = 1'b0;
        tick(2);
        preset = 1'b0;
        tick(1);
        check("in_ready_after_areset", in_ready, 1'b1);
        mon_en = 1'b1;

        // en dropped while waiting in PRIME on an empty FIFO
        en = 1'b1;
        tick(1);
        check("busy_en_1cycle", busy, 1'b1);
        tick(3);
        check("prime_holds_empty", busy, 1'b1);
        en = 1'b0;
        tick(1);
        check("prime_abort", busy, 1'b0);

        // pushes accepted from empty until full
        feed_on = 1'b1;
        pushes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (in_valid && in_ready) pushes++;
            else if (!in_ready) break;
        end
        check("pushes_to_full", pushes, DEPTH);
        feed_on = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/down_frame_sched.md
# down_frame_sched

Frame scheduler that feeds the down176 decimator. It buffers stereo sample pairs from the source in a small FIFO and generates the bit clock (ibick) and word clock (ilrck) for the selected PCM rate. It presents one held left/right pair per frame and sequences start, stop and rate changes on frame boundaries, replacing the ad-hoc clk_d2/wlrck/num generation in bench and top level.

## Interface
- DW, 32, sample width per channel
- DEPTH, 4, FIFO depth in stereo pairs (power of 2, ≥2)
- pclk  in  1  master clock, 45.1584 MHz
- preset  in  1  asynchronous, active-high reset
- en  in  1  run request; level-sensitive
- ctrl  in  2  rate select: PCM441=00, PCM882=01, PCM176=10, PCM352=11
- in_valid  in  1  source pair valid
- in_ready  out  1  FIFO can accept; = !full
- in_l, in_r  in  DW  signed source pair
- obick  out  1  bit clock to decimator (ibick)
- olrck  out  1  word clock to decimator (ilrck); 0 = left half, 1 = right half
- oldata, ordata  out  DW  signed held pair to decimator (ldata/rdata)
- busy  out  1  state ≠ IDLE
- underrun  out  1  one-cycle pulse: frame boundary with empty FIFO
- rate_chg  out  1  one-cycle pulse: new rate applied

## Operation
- Frame length FL in pclk by active rate: 11→128, 10→256, 01→512, 00→1024; half HL = FL/2. Counter cnt is 10 bits.
- States:
  - IDLE: cnt, obick, olrck = 0; oldata/ordata = 0; FIFO accepts pushes; act_rate ← ctrl every cycle. en=1 → PRIME.
  - PRIME: wait for FIFO count ≥ 2 → RUN. en=0 → IDLE.
  - RUN: obick toggles every pclk. At cnt = HL−1, olrck ← 1. At cnt = FL−1, frame boundary: cnt ← 0, olrck ← 0, pop. Otherwise cnt ← cnt+1. en=0 sampled at a boundary → IDLE (DRAIN is implicit: current frame always completes).
- Pop: oldata/ordata ← FIFO head. If the FIFO is empty: outputs ← 0 and underrun pulses; stay in RUN.
- Entering RUN (edge leaving PRIME): cnt ← 0, olrck ← 0, obick ← 0, first pop at the same edge.
- Rate change: in RUN, ctrl is compared against act_rate only at a boundary; on mismatch act_rate ← ctrl and rate_chg pulses, and the next frame uses the new FL. ctrl changes mid-frame are ignored until then. In IDLE, act_rate tracks ctrl without a rate_chg pulse.
- FIFO: push when in_valid & in_ready; simultaneous push and pop leaves count unchanged. Full → in_ready = 0. Contents are kept across RUN→IDLE and cleared only by preset.
- Arithmetic: data passes through unmodified (no saturation). Count width is log2(DEPTH)+1.

## Timing
- Reset values: obick 0, olrck 0, oldata/ordata 0, in_ready 0 while preset is high and 1 after (FIFO empty), busy 0, underrun 0, rate_chg 0, state IDLE, act_rate = 00.
- en → busy: 1 cycle. PRIME → RUN: 1 cycle after count ≥ 2 is registered.
- Push → visible on oldata: at the earliest, the next boundary after the push edge.
- All outputs are registered. obick duty is 50% with period 2 pclk. olrck period is FL with 50% duty.
- preset asserted mid-frame: all state clears immediately (async) and the FIFO empties.
- en dropping in PRIME: return to IDLE next cycle.

## Structure
- Package down_pkg: rate encodings PCM441/PCM882/PCM176/PCM352, the state enum (IDLE, PRIME, RUN), and a function mapping rate to FL; the decimator shares these.
- One sub-module, pair_fifo: synchronous FIFO of width 2·DW and depth DEPTH, with push/pop/count/full/empty.

## Test plan
- Reset release, ctrl=10, prefill 2 pairs (l=1000, r=−1000), en=1 → obick toggles every pclk; olrck rises at cnt 127 and falls at cnt 255; oldata=1000, ordata=−1000 from the first RUN cycle.
- ctrl=11 and 00 → olrck period 128 and 1024 pclk respectively.
- Feed only 3 pairs, run 5 frames → oldata = 0 on frames 4 and 5; underrun pulses exactly twice, each at a boundary edge.
- ctrl 10→11 at cnt 50 → current frame stays 256; rate_chg pulses at the boundary; next frame is 128.
- en=0 at cnt 10 of a 256 frame → frame completes; IDLE at boundary; busy falls; obick/olrck = 0.
- DEPTH=4 with continuous in_valid → in_ready falls after 4 pushes and reasserts the cycle after each pop; preset mid-frame → all outputs 0 the same cycle.
